multi_cycle_control: RTL
========================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL have parameters, one per line (name, default, meaning):
  OPW, 11, opcode width (instruction bits [31:21]).
  ALUOPW, 4, ALU operation field width.
  SIGNOPW, 3, sign-extend select width.
  CNTW, 16, retired-instruction counter width.
  TMO, 255, memory-wait timeout in cycles (range 1..2^16-1).
REQ-002 The block SHALL have ports, one per line (name, direction, width, meaning):
  CLK  in  1  sole clock; all state updates on its rising edge.
  Reset_L  in  1  asynchronous, active-low reset.
  instr_op  in  OPW  opcode bits of the fetched instruction word.
  imem_ready  in  1  instruction memory data valid.
  dmem_ready  in  1  data memory access complete.
  imem_req  out  1  instruction fetch request.
  irwrite  out  1  latch fetched instruction / increment PC.
  reg2loc, alusrc, mem2reg, regwrite  out  1 each  datapath selects and enables.
  memread, memwrite  out  1 each  data memory request.
  branch, uncond_branch  out  1 each  conditional and unconditional PC update.
  aluop  out  ALUOPW  ALU operation.
  signop  out  SIGNOPW  immediate extension type.
  busy  out  1  high in every state except FETCH.
  fault  out  1  sticky illegal-opcode or timeout flag.
  retired  out  CNTW  count of completed instructions.

Function
REQ-003 Decode SHALL use 11-bit wildcard patterns (bit 10 = MSB, ? = don't care): ANDREG ?0001010???, ORRREG ?0101010???, ADDREG ?0?01011???, SUBREG ?1?01011???, ADDIMM ?0?10001???, SUBIMM ?1?10001???, MOVZ 110100101??, B ?00101?????, CBZ ?011010????, LDUR ??111000010, STUR ??111000000. When patterns overlap, the first match in this order SHALL win: LDUR, STUR, MOVZ, ADDREG, SUBREG, ANDREG, ORRREG, ADDIMM, SUBIMM, CBZ, B.
REQ-004 The FSM SHALL have six states: FETCH, DECODE, EXEC, MEM, WB, FAULT.
REQ-005 FETCH SHALL assert imem_req. When imem_ready=1, FETCH SHALL pulse irwrite for that cycle, capture instr_op into op_q and go to DECODE. Otherwise it SHALL remain in FETCH.
REQ-006 DECODE SHALL go to EXEC if op_q matches a pattern, and to FAULT otherwise.
REQ-007 EXEC SHALL drive the ALU controls from op_q and then transition as follows:
  LDUR, STUR -> MEM.
  register, immediate and MOVZ instructions -> WB.
  CBZ -> FETCH, with branch=1 for this cycle.
  B -> FETCH, with uncond_branch=1 for this cycle.
REQ-008 MEM SHALL hold memread (LDUR) or memwrite (STUR) high until dmem_ready=1. It SHALL then go to WB (LDUR) or FETCH (STUR).
REQ-009 WB SHALL assert regwrite for exactly one cycle, with mem2reg=1 for LDUR only, and then go to FETCH.
REQ-010 Control values SHALL be held in DECODE, EXEC, MEM and WB:
  ADD: aluop 0010.  SUB: aluop 0110.  AND: aluop 0000.  ORR: aluop 0001.
  CBZ: aluop 0111.  MOVZ: aluop 0111.  B: aluop 0000.  LDUR, STUR: aluop 0010.
  signop: D-type 000, CBZ 001, immediate 010, B 011, MOVZ 100.
  alusrc=1 for immediate, MOVZ, LDUR and STUR.
  reg2loc=1 for STUR and CBZ.
REQ-011 All control outputs SHALL be Moore outputs decoded from the state and op_q, never from instr_op directly (except the op_q capture in FETCH).
REQ-012 A wait counter SHALL reset on entry to FETCH and to MEM. If a ready signal is still 0 after TMO cycles, the FSM SHALL go to FAULT.
REQ-013 FAULT SHALL drive all control outputs to 0, set fault=1 and busy=1, and remain in FAULT until reset.
REQ-014 retired SHALL increment by 1 on the cycle an instruction leaves its last state: EXEC for B/CBZ, MEM for STUR, WB for all others. It SHALL wrap from 2^CNTW-1 to 0.
REQ-015 A ready input asserted in a state that does not wait on it SHALL be ignored.

Reset
REQ-016 Reset_L=0 SHALL immediately (asynchronously) set:
  state=FETCH, op_q=0, wait counter=0, retired=0, fault=0.
  every control output=0, except imem_req, which follows FETCH (1 after reset).
REQ-017 A reset asserted mid-MEM SHALL drop memread/memwrite in the same cycle, and the aborted instruction SHALL NOT be counted.

Verification
REQ-018 ADDREG: op 10001011000, imem_ready=1 -> irwrite in cycle 0; regwrite=1 with aluop=0010 in cycle 3; retired=1 after cycle 3.
REQ-019 LDUR: op 11111000010, dmem_ready delayed 3 cycles -> memread held 4 cycles; then a WB cycle with mem2reg=1 and regwrite=1.
REQ-020 CBZ: op 10110100000 -> branch=1, signop=001, reg2loc=1 in EXEC; back in FETCH next cycle; retired increments.
REQ-021 Illegal op 00000000000 -> FAULT after DECODE, fault=1 sticky; a reset pulse clears it to FETCH with fault=0.
REQ-022 TMO=4, STUR with dmem_ready held 0 -> FAULT after 4 MEM cycles; memwrite=0 in FAULT; retired unchanged.
REQ-023 CNTW=2, five back-to-back B instructions -> retired reads 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/multi_cycle_control.sv
// ---------------------------------------------------------------------------
// multi_cycle_control
//
// Multi-cycle controller for a small ARM-like datapath. Each instruction
// passes through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The controller
// decodes the opcode captured in FETCH and drives the datapath selects,
// enables and memory requests. An illegal opcode or a memory-wait timeout
// sends it to FAULT, where it stays until reset.
//
// Parameters
//   OPW      opcode width (instruction bits [31:21])
//   ALUOPW   ALU operation field width
//   SIGNOPW  sign-extend select width
//   CNTW     retired-instruction counter width
//   TMO      memory-wait timeout in cycles (1 .. 2^16-1)
//
// Ports
//   CLK            clock, rising edge
//   Reset_L        asynchronous active-low reset
//   instr_op       opcode bits of the fetched instruction word
//   imem_ready     instruction memory data valid
//   dmem_ready     data memory access complete
//   imem_req       instruction fetch request
//   irwrite        latch fetched instruction / increment PC
//   reg2loc, alusrc, mem2reg, regwrite   datapath selects and enables
//   memread, memwrite                    data memory request
//   branch, uncond_branch                conditional / unconditional PC update
//   aluop          ALU operation
//   signop         immediate extension type
//   busy           high in every state except FETCH
//   fault          sticky illegal-opcode or timeout flag
//   retired        count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multi_cycle_control #(
    parameter int OPW     = 11,
    parameter int ALUOPW  = 4,
    parameter int SIGNOPW = 3,
    parameter int CNTW    = 16,
    parameter int TMO     = 255
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [OPW-1:0]     instr_op,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               irwrite,
    output logic               reg2loc,
    output logic               alusrc,
    output logic               mem2reg,
    output logic               regwrite,
    output logic               memread,
    output logic               memwrite,
    output logic               branch,
    output logic               uncond_branch,
    output logic [ALUOPW-1:0]  aluop,
    output logic [SIGNOPW-1:0] signop,
    output logic               busy,
    output logic               fault,
    output logic [CNTW-1:0]    retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_LDUR,
        OP_STUR,
        OP_MOVZ,
        OP_ADDREG,
        OP_SUBREG,
        OP_ANDREG,
        OP_ORRREG,
        OP_ADDIMM,
        OP_SUBIMM,
        OP_CBZ,
        OP_B
    } op_class_t;

    state_t          state_reg, state_next;
    logic [OPW-1:0]  op_reg, op_next;          // opcode captured in FETCH
    logic [15:0]     wait_reg, wait_next;      // cycles spent waiting on a ready
    logic [CNTW-1:0] retired_reg;

    op_class_t          op_class;
    logic [ALUOPW-1:0]  dec_aluop;
    logic [SIGNOPW-1:0] dec_signop;
    logic               dec_alusrc;
    logic               dec_reg2loc;
    logic               hold;                  // decoded controls are driven
    logic               retire;                // instruction completes this cycle
    logic               timeout;

    // -----------------------------------------------------------------------
    // Opcode classification. casez takes the first matching item, which
    // gives the required priority when patterns overlap.
    // -----------------------------------------------------------------------
    always_comb begin
        op_class = OP_NONE;
        casez (op_reg)
            11'b??111000010: op_class = OP_LDUR;
            11'b??111000000: op_class = OP_STUR;
            11'b110100101??: op_class = OP_MOVZ;
            11'b?0?01011???: op_class = OP_ADDREG;
            11'b?1?01011???: op_class = OP_SUBREG;
            11'b?0001010???: op_class = OP_ANDREG;
            11'b?0101010???: op_class = OP_ORRREG;
            11'b?0?10001???: op_class = OP_ADDIMM;
            11'b?1?10001???: op_class = OP_SUBIMM;
            11'b?011010????: op_class = OP_CBZ;
            11'b?00101?????: op_class = OP_B;
            default:         op_class = OP_NONE;
        endcase
    end

    // Per-class control values, held from DECODE through WB.
    always_comb begin
        dec_aluop   = '0;
        dec_signop  = '0;
        dec_alusrc  = 1'b0;
        dec_reg2loc = 1'b0;
        case (op_class)
            OP_LDUR: begin
                dec_aluop  = ALUOPW'(4'b0010);
                dec_signop = SIGNOPW'(3'b000);
                dec_alusrc = 1'b1;
            end
            OP_STUR: begin
                dec_aluop   = ALUOPW'(4'b0010);
                dec_signop  = SIGNOPW'(3'b000);
                dec_alusrc  = 1'b1;
                dec_reg2loc = 1'b1;
            end
            OP_MOVZ: begin
                dec_aluop  = ALUOPW'(4'b0111);
                dec_signop = SIGNOPW'(3'b100);
                dec_alusrc = 1'b1;
            end
            OP_ADDREG: dec_aluop = ALUOPW'(4'b0010);
            OP_SUBREG: dec_aluop = ALUOPW'(4'b0110);
            OP_ANDREG: dec_aluop = ALUOPW'(4'b0000);
            OP_ORRREG: dec_aluop = ALUOPW'(4'b0001);
            OP_ADDIMM: begin
                dec_aluop  = ALUOPW'(4'b0010);
                dec_signop = SIGNOPW'(3'b010);
                dec_alusrc = 1'b1;
            end
            OP_SUBIMM: begin
                dec_aluop  = ALUOPW'(4'b0110);
                dec_signop = SIGNOPW'(3'b010);
                dec_alusrc = 1'b1;
            end
            OP_CBZ: begin
                dec_aluop   = ALUOPW'(4'b0111);
                dec_signop  = SIGNOPW'(3'b001);
                dec_reg2loc = 1'b1;
            end
            OP_B: begin
                dec_aluop  = ALUOPW'(4'b0000);
                dec_signop = SIGNOPW'(3'b011);
            end
            default: ;
        endcase
    end

    // The wait counter restarts whenever a waiting state is entered, so the
    // last allowed cycle is the one where it reads TMO-1.
    assign timeout = (wait_reg == 16'(TMO - 1));

    // -----------------------------------------------------------------------
    // Next state and Moore outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        hold          = 1'b0;
        retire        = 1'b0;
        imem_req      = 1'b0;
        irwrite       = 1'b0;
        mem2reg       = 1'b0;
        regwrite      = 1'b0;
        memread       = 1'b0;
        memwrite      = 1'b0;
        branch        = 1'b0;
        uncond_branch = 1'b0;
        fault         = 1'b0;

        case (state_reg)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    // Suppressed while reset is held so all strobes read 0.
                    irwrite    = Reset_L;
                    op_next    = instr_op;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                hold       = 1'b1;
                state_next = (op_class == OP_NONE) ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                hold = 1'b1;
                case (op_class)
                    OP_LDUR, OP_STUR: state_next = S_MEM;
                    OP_CBZ: begin
                        branch     = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_B: begin
                        uncond_branch = 1'b1;
                        retire        = 1'b1;
                        state_next    = S_FETCH;
                    end
                    OP_NONE: state_next = S_FAULT;
                    default: state_next = S_WB;
                endcase
            end
            S_MEM: begin
                hold     = 1'b1;
                memread  = (op_class == OP_LDUR);
                memwrite = (op_class == OP_STUR);
                if (dmem_ready) begin
                    if (op_class == OP_LDUR) begin
                        state_next = S_WB;
                    end else begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                hold       = 1'b1;
                regwrite   = 1'b1;
                mem2reg    = (op_class == OP_LDUR);
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: state_next = S_FAULT;
        endcase
    end

    assign aluop   = hold ? dec_aluop   : '0;
    assign signop  = hold ? dec_signop  : '0;
    assign alusrc  = hold & dec_alusrc;
    assign reg2loc = hold & dec_reg2loc;
    assign busy    = (state_reg != S_FETCH);
    assign retired = retired_reg;

    always_comb begin
        wait_next = wait_reg;
        if (state_next != state_reg) begin
            wait_next = '0;
        end else if (state_reg == S_FETCH || state_reg == S_MEM) begin
            wait_next = wait_reg + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_reg   <= S_FETCH;
            op_reg      <= '0;
            wait_reg    <= '0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            wait_reg    <= wait_next;
            retired_reg <= retired_reg + CNTW'(retire);
        end
    end

endmodule
